sram_image_loader: RTL

//  Host-side front end for the binary 3x3 convolution engine. It accepts a

---
 rtl/sram_image_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sram_image_loader.sv
// sram_image_loader: packs a valid/ready image stream into the engine's input SRAM, then runs the engine and reports done/err.
// Optional LOADER_ROW_MASK_EN: clear row bits at and above the image dim before writing.
module sram_image_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] TERM_WORD = DATA_W'(16'h00FF),
  parameter logic [7:0] BUSY_TMO = 8'd255
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_eos,
  output logic [ADDR_W-1:0] sram_write_address,
  output logic [DATA_W-1:0] sram_write_data,
  output logic              sram_write_enable,
  output logic              dut_run,
  input  logic              dut_busy,
  output logic [7:0]        image_count,
  output logic              done,
  output logic [2:0]        err
);
`ifdef LOADER_ROW_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, HDR, ROW, DRAIN, TERM, RUN, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state;
  logic [4:0] rows_left;
  logic [7:0] tmo;
  logic [DATA_W-1:0] row_mask, row_data;
  logic [ADDR_W-1:0] next_addr;
  logic xfer, ovf, bad;
  assign in_ready = state inside {HDR, ROW, DRAIN};
  assign xfer = in_valid & in_ready;
  // address the next accepted word lands on, accounting for a write still in flight
  assign next_addr = sram_write_address + ADDR_W'(sram_write_enable);
  assign ovf = &next_addr;
  assign bad = ovf | (state == HDR ? !(in_data[4:0] inside {5'd10, 5'd12, 5'd16}) | in_eos
                                   : in_eos & (rows_left != 5'd1));
  assign row_data = MASK_EN ? in_data & row_mask : in_data;
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
      sram_write_address <= BASE_ADDR;
      sram_write_data <= '0;
      sram_write_enable <= 1'b0;
      dut_run <= 1'b0;
      image_count <= '0;
      done <= 1'b0;
      err <= '0;
      rows_left <= '0;
      tmo <= '0;
      row_mask <= '1;
    end else begin
      sram_write_enable <= 1'b0;
      dut_run <= 1'b0;
      done <= 1'b0;
      sram_write_address <= next_addr;
      case (state)
        IDLE: if (start && !done) begin
          state <= HDR;
          err <= '0;
          image_count <= '0;
          sram_write_address <= BASE_ADDR;
        end
        HDR, ROW: if (xfer) begin
          if (bad) begin
            err <= err | {1'b0, ovf, !ovf};
            done <= in_eos;
            state <= in_eos ? IDLE : DRAIN;
          end else begin
            sram_write_enable <= 1'b1;
            if (state == HDR) begin
              sram_write_data <= in_data;
              rows_left <= in_data[4:0];
              row_mask <= ~({DATA_W{1'b1}} << in_data[4:0]);
              state <= ROW;
            end else begin
              sram_write_data <= row_data;
              rows_left <= rows_left - 5'd1;
              if (rows_left == 5'd1) begin
                image_count <= image_count + 8'd1;
                state <= in_eos ? TERM : HDR;
              end
            end
          end
        end
        DRAIN: if (xfer && in_eos) begin
          done <= 1'b1;
          state <= IDLE;
        end
        TERM: begin
          sram_write_enable <= 1'b1;
          sram_write_data <= TERM_WORD;
          state <= RUN;
        end
        RUN: begin
          dut_run <= 1'b1;
          tmo <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (dut_busy) state <= WAIT_DONE;
          else if (tmo == BUSY_TMO - 8'd1) begin
            err[2] <= 1'b1;
            done <= 1'b1;
            state <= IDLE;
          end else tmo <= tmo + 8'd1;
        WAIT_DONE: if (!dut_busy) begin
          done <= 1'b1;
          state <= IDLE;
          sram_write_address <= BASE_ADDR;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
